adder4bit_sweep_checker: RTL and testbench
==========================================

Name: adder4bit_sweep_checker

Overview:
Synchronous, self-timed stimulus and checker stage for the 4-bit adder DUT. It drives the adder's A/B/Cin inputs and consumes its S/Cout outputs. On start it sweeps every {A,B,Cin} combination, compares each result against an internal golden sum, and reports pass/fail, an error count and the first failing vector. It replaces free-running testers with a clocked, deterministic harness usable in both simulation and on-board self-test.

Parameters:
WIDTH, 4, operand width of A, B and S.
SETTLE_CYCLES, 2, clock cycles allowed after driving a vector before S/Cout are sampled; legal range ≥1.
ERR_W, 16, width of the error counter.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begins a sweep when sampled high in IDLE or DONE.
a_o  output  WIDTH  A operand driven to the adder.
b_o  output  WIDTH  B operand driven to the adder.
cin_o  output  1  carry-in driven to the adder.
s_i  input  WIDTH  sum returned by the adder.
cout_i  input  1  carry-out returned by the adder.
busy  output  1  high from the cycle after start until the sweep completes.
done  output  1  high in the DONE state.
pass  output  1  valid while done is high: 1 if err_count==0.
err_count  output  ERR_W  number of mismatching vectors; saturates at all-ones.
first_err_valid  output  1  set on the first mismatch of a sweep.
first_err_vec  output  2*WIDTH+1  {A,B,Cin} of the first mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All registers update on the rising edge of clk.
- Reset values: a_o=0, b_o=0, cin_o=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, state=IDLE. rst has priority over all other inputs. rst asserted mid-sweep aborts the sweep; the block returns to these values on the next edge.
- Vector index vec has width 2*WIDTH+1 and maps as {a_o,b_o,cin_o}=vec, with Cin as the LSB. The sweep runs vec=0 up to 2^(2*WIDTH+1)-1 in ascending order (512 vectors at the default width).
- Golden result: the (WIDTH+1)-bit sum a_o+b_o+cin_o. It is compared against {cout_i,s_i}.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE, start=1: set vec=0 and drive vector 0; clear err_count, first_err_valid and first_err_vec; set wait_cnt=0 and busy=1; go to WAIT.
- WAIT: wait_cnt increments each cycle. When wait_cnt==SETTLE_CYCLES-1, go to CHECK. Outputs are held stable.
- CHECK (one cycle):
  - On mismatch, err_count increments unless already all-ones.
  - If first_err_valid==0 on a mismatch, set first_err_valid=1 and first_err_vec=vec.
  - If vec is the last index, go to DONE. Otherwise increment vec, drive the new vector, clear wait_cnt and go to WAIT.
- DONE: busy=0, done=1, pass=(err_count==0). a_o, b_o and cin_o hold the last vector. start=1 restarts exactly as from IDLE, and done drops on that edge.
- start is ignored while busy. Holding start high continuously restarts a new sweep on each entry to DONE, after one cycle spent in DONE.
- Per-vector period is SETTLE_CYCLES+1 cycles. A full sweep takes 2^(2*WIDTH+1)*(SETTLE_CYCLES+1) cycles from the start edge to the done edge: 1536 at the defaults.
- The error count and first-failing-vector capture in the same CHECK cycle use the pre-increment err_count; there is no double counting.

Test Plan:
- Ideal behavioural adder connected, start pulsed 1 cycle → busy for 1536 cycles, then done=1, pass=1, err_count=0, first_err_valid=0.
- Adder model with cout_i stuck 0 → done after 1536 cycles, pass=0, err_count=256, first_err_valid=1, first_err_vec=9'h01F (A=0, B=15, Cin=1).
- Adder model with s_i[0] stuck 0 → err_count=256, first_err_vec=9'h001, pass=0.
- rst asserted for 1 cycle at cycle 100 of a sweep → next edge has all outputs at reset values and state IDLE; a fresh start then gives a clean 1536-cycle sweep with pass=1.
- start pulsed at cycles 10 and 500 of a sweep → both ignored; done still at cycle 1536 and vec order unchanged. start held high in DONE → done high exactly 1 cycle, then a new sweep runs with err_count cleared.
- SETTLE_CYCLES=1, and a model whose output lags 2 cycles → errors reported (err_count>0). The same lagging model with SETTLE_CYCLES=3 → pass=1.

Source files
------------

// File: rtl/adder4bit_sweep_checker.sv
// Clocked exhaustive stimulus/checker for a WIDTH-bit adder: sweeps every {A,B,Cin},
// compares {cout,s} against a golden sum, and records error count and first failing vector.
module adder4bit_sweep_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               cin_o,
    input  logic [WIDTH-1:0]   s_i,
    input  logic               cout_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_err_valid,
    output logic [2*WIDTH:0]   first_err_vec
);

    localparam int VEC_W = 2 * WIDTH + 1;
    localparam int WC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [VEC_W-1:0] LAST_VEC  = {VEC_W{1'b1}};
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reference sum for a packed {A,B,Cin} vector; Cin sits in the LSB.
    function automatic logic [WIDTH:0] golden_sum(input logic [VEC_W-1:0] v);
        return {1'b0, v[VEC_W-1 -: WIDTH]} + {1'b0, v[WIDTH:1]} + {{WIDTH{1'b0}}, v[0]};
    endfunction

    state_t            state_r, state_s;
    logic [VEC_W-1:0]  vec_r, vec_s;
    logic [WC_W-1:0]   wait_r, wait_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              pass_r, pass_s;
    logic [ERR_W-1:0]  err_r, err_s;
    logic              fev_r, fev_s;
    logic [VEC_W-1:0]  fvec_r, fvec_s;
    logic              mismatch_s;

    assign {a_o, b_o, cin_o} = vec_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_count       = err_r;
    assign first_err_valid = fev_r;
    assign first_err_vec   = fvec_r;

    // Next-state and next-register computation for the sweep FSM.
    always_comb begin
        state_s    = state_r;
        vec_s      = vec_r;
        wait_s     = wait_r;
        busy_s     = busy_r;
        done_s     = done_r;
        pass_s     = pass_r;
        err_s      = err_r;
        fev_s      = fev_r;
        fvec_s     = fvec_r;
        mismatch_s = (golden_sum(vec_r) != {cout_i, s_i});

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_WAIT;
                    vec_s   = {VEC_W{1'b0}};
                    wait_s  = {WC_W{1'b0}};
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                    err_s   = {ERR_W{1'b0}};
                    fev_s   = 1'b0;
                    fvec_s  = {VEC_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT: begin
                if (wait_r == WAIT_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    wait_s = wait_r + WC_W'(1);
                end
            end
            ST_CHECK: begin
                // Capture uses the pre-increment count, so one vector is never counted twice.
                if (mismatch_s) begin
                    if (err_r != ERR_MAX) begin
                        err_s = err_r + ERR_W'(1);
                    end else begin
                        err_s = err_r;
                    end
                    if (!fev_r) begin
                        fev_s  = 1'b1;
                        fvec_s = vec_r;
                    end else begin
                        fvec_s = fvec_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (vec_r == LAST_VEC) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_s == {ERR_W{1'b0}});
                end else begin
                    state_s = ST_WAIT;
                    vec_s   = vec_r + VEC_W'(1);
                    wait_s  = {WC_W{1'b0}};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            vec_r   <= {VEC_W{1'b0}};
            wait_r  <= {WC_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= {ERR_W{1'b0}};
            fev_r   <= 1'b0;
            fvec_r  <= {VEC_W{1'b0}};
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            wait_r  <= wait_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            fev_r   <= fev_s;
            fvec_r  <= fvec_s;
        end
    end

endmodule

// File: tb/tb_adder4bit_sweep_checker.sv
// Bench for adder4bit_sweep_checker: a fault-injectable adder model, randomized faults,
// and a sweep-level reference model computing expected error counts and first failure.
module tb_adder4bit_sweep_checker;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] a_o, b_o, s_i;
    logic       cin_o, cout_i, busy, done, pass, fev;
    logic [15:0] errc;
    logic [8:0] fvec;
    logic [4:0] fault_mask, fault_val, good_sum;

    logic [3:0] a1, b1, s1, a3, b3, s3;
    logic       c1, co1, busy1, done1, pass1, fev1;
    logic       c3, co3, busy3, done3, pass3, fev3;
    logic [15:0] err1, err3;
    logic [8:0] fvec1, fvec3;
    logic [4:0] p1_1, p1_2, p3_1, p3_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Adder under test: ideal sum with selected result bits forced to fault_val.
    always_comb begin
        good_sum = {1'b0, a_o} + {1'b0, b_o} + {4'b0000, cin_o};
        {cout_i, s_i} = (good_sum & ~fault_mask) | (fault_val & fault_mask);
    end

    // Two-cycle-latency adders feeding the short- and long-settle checkers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_1 <= 5'd0; p1_2 <= 5'd0; p3_1 <= 5'd0; p3_2 <= 5'd0;
        end else begin
            p1_1 <= {1'b0, a1} + {1'b0, b1} + {4'b0000, c1};
            p1_2 <= p1_1;
            p3_1 <= {1'b0, a3} + {1'b0, b3} + {4'b0000, c3};
            p3_2 <= p3_1;
        end
    end
    assign {co1, s1} = p1_2;
    assign {co3, s3} = p3_2;

    adder4bit_sweep_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o), .cin_o(cin_o),
        .s_i(s_i), .cout_i(cout_i), .busy(busy), .done(done), .pass(pass),
        .err_count(errc), .first_err_valid(fev), .first_err_vec(fvec)
    );

    adder4bit_sweep_checker #(.SETTLE_CYCLES(1)) u_lag1 (
        .clk(clk), .rst(rst), .start(start), .a_o(a1), .b_o(b1), .cin_o(c1),
        .s_i(s1), .cout_i(co1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_valid(fev1), .first_err_vec(fvec1)
    );

    adder4bit_sweep_checker #(.SETTLE_CYCLES(3)) u_lag3 (
        .clk(clk), .rst(rst), .start(start), .a_o(a3), .b_o(b3), .cin_o(c3),
        .s_i(s3), .cout_i(co3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_valid(fev3), .first_err_vec(fvec3)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sweep outcome for a stuck-at fault, enumerated in ascending A,B,Cin order.
    task automatic ref_sweep(input logic [4:0] m, input logic [4:0] v, output int errs,
                             output logic efv, output logic [8:0] evec);
        errs = 0; efv = 1'b0; evec = 9'd0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    int good, obs;
                    good = a + b + c;
                    obs  = (good & ~int'(m)) | (int'(v) & int'(m));
                    if (obs != good) begin
                        errs++;
                        if (!efv) begin
                            efv  = 1'b1;
                            evec = 9'(a * 32 + b * 2 + c);
                        end
                    end
                end
    endtask

    task automatic run_sweep(input string name, input logic [4:0] m, input logic [4:0] v,
                             input bit strays);
        int ee, n, badord;
        logic efv;
        logic [8:0] evec;
        fault_mask = m;
        fault_val  = v;
        ref_sweep(m, v, ee, efv, evec);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val({name, "_busy"}, busy, 1);
        n = 0;
        badord = 0;
        while (!done && n < 2000) begin
            start = (strays && (n == 10 || n == 500)) ? 1'b1 : 1'b0;
            tick();
            n++;
            if (!done && {a_o, b_o, cin_o} != 9'(n / 3)) badord++;
        end
        start = 1'b0;
        check_val({name, "_cycles"}, n, 1536);
        check_val({name, "_done"}, done, 1);
        check_val({name, "_busy_end"}, busy, 0);
        check_val({name, "_pass"}, pass, (ee == 0) ? 1 : 0);
        check_val({name, "_errc"}, errc, ee);
        check_val({name, "_fev"}, fev, efv);
        check_val({name, "_fvec"}, fvec, evec);
        check_val({name, "_order"}, badord, 0);
    endtask

    initial begin
        int n, t1, t3, lag_errs, prev, cur;
        logic [4:0] rm, rv;
        rst = 1'b1; start = 1'b0; fault_mask = 5'd0; fault_val = 5'd0;
        tick(); tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pass", pass, 0);
        check_val("rst_errc", errc, 0);
        check_val("rst_vec", {a_o, b_o, cin_o, fev, fvec}, 0);
        rst = 1'b0;
        tick();

        run_sweep("ideal_strays", 5'h00, 5'h00, 1'b1);
        run_sweep("cout_stuck0", 5'h10, 5'h00, 1'b0);
        run_sweep("s0_stuck0", 5'h01, 5'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rm = 5'($urandom_range(1, 31));
            rv = 5'($urandom_range(0, 31));
            run_sweep("random_fault", rm, rv, 1'b0);
        end

        // Abort a faulty sweep with reset, then re-run clean.
        fault_mask = 5'h10; fault_val = 5'h00;
        start = 1'b1; tick(); start = 1'b0;
        repeat (99) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_errc", errc, 0);
        check_val("abort_vec", {a_o, b_o, cin_o, fev, fvec, pass}, 0);
        run_sweep("after_abort", 5'h00, 5'h00, 1'b0);

        // start held high across DONE: exactly one DONE cycle, then a fresh sweep.
        fault_mask = 5'h10; fault_val = 5'h00;
        start = 1'b1; tick();
        n = 0;
        while (!done && n < 2000) begin tick(); n++; end
        check_val("held_done", done, 1);
        check_val("held_errc_before", errc, 256);
        fault_mask = 5'h00;
        tick();
        check_val("held_done_dropped", done, 0);
        check_val("held_busy", busy, 1);
        check_val("held_errc_cleared", errc, 0);
        start = 1'b0;
        n = 0;
        while (!done && n < 2000) begin tick(); n++; end
        check_val("held_cycles", n, 1536);
        check_val("held_pass", pass, 1);

        // Lagging adder: one cycle of settle sees the previous vector's sum.
        lag_errs = 0; prev = 0;
        for (int k = 0; k < 512; k++) begin
            cur = (k >> 5) + ((k >> 1) & 15) + (k & 1);
            if (cur != prev) lag_errs++;
            prev = cur;
        end
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0; t1 = -1; t3 = -1;
        while ((t1 < 0 || t3 < 0) && n < 2200) begin
            tick(); n++;
            if (done1 && t1 < 0) t1 = n;
            if (done3 && t3 < 0) t3 = n;
        end
        check_val("lag1_cycles", t1, 1024);
        check_val("lag3_cycles", t3, 2048);
        check_val("lag1_errc", err1, lag_errs);
        check_val("lag1_pass", pass1, 0);
        check_val("lag1_fvec", {fev1, fvec1}, 10'h201);
        check_val("lag3_pass", pass3, 1);
        check_val("lag3_errc", {err3, fev3}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
